wish_pack: RTL and testbench
============================

Name: wish_pack

Overview:
Wishbone-style packer. Collects NUM_PACK narrow beats of DATA_WIDTH bits from a source port and emits one wide word of DATA_WIDTH*NUM_PACK bits on a destination port. It is the inverse of the existing unpacker, and tag semantics mirror it: tgc[0] marks the first beat of a group and tgc[1] marks the last. It sits between a narrow stream producer and a wide consumer.

Parameters:
DATA_WIDTH, 8, width of one narrow beat.
NUM_PACK, 4, beats per wide word; legal values are 2 or more.
LITTLE_ENDIAN, 1, lane order. 1: beat k goes to d_dat_o[k*DATA_WIDTH +: DATA_WIDTH]. 0: beat k goes to lane NUM_PACK-1-k.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_ni  in  1  asynchronous, active-low reset.
s_stb_i  in  1  source strobe.
s_cyc_i  in  1  source cycle.
s_ack_o  out  1  source ack; a beat transfers when s_stb_i & s_cyc_i & s_ack_o.
s_stall_o  out  1  source stall.
s_dat_i  in  DATA_WIDTH  narrow beat.
s_tgc_i  in  2  beat tag: [0] first, [1] last.
d_stb_o  out  1  wide word valid.
d_cyc_o  out  1  destination cycle; always equal to d_stb_o.
d_ack_i  in  1  destination ack; a word transfers when d_stb_o & d_ack_i.
d_dat_o  out  DATA_WIDTH*NUM_PACK  packed word.
d_tgc_o  out  2  word tag.

Behaviour:
- Reset is asynchronous and active-low. On reset: index=0, accumulator=0, out_valid=0, d_stb_o=0, d_cyc_o=0, d_dat_o=0, d_tgc_o=0. Any partial group is discarded. Reset may assert at any cycle, mid-group or mid-handshake.
- Storage: an accumulator (lanes 0..NUM_PACK-2 plus a tag register) and an output register holding d_dat_o/d_tgc_o/out_valid.
- Index counter runs 0..NUM_PACK-1 and wraps to 0 after the last beat. Counter width is $clog2(NUM_PACK).
- Stall condition: s_stall_o = (index==NUM_PACK-1) & out_valid & !d_ack_i.
- Ack: s_ack_o = s_stb_i & s_cyc_i & !s_stall_o. This is combinational, so the d_ack_i -> s_ack_o path is intended.
- Accepted beat at index < NUM_PACK-1:
  - write its lane, index++.
  - at index 0, latch s_tgc_i[0] as the first flag.
  - tag bits of middle beats are ignored.
- Accepted beat at index NUM_PACK-1:
  - on the next edge, the output register loads {accumulator lanes, this beat}.
  - d_tgc_o = {s_tgc_i[1] of this beat, latched first flag}.
  - out_valid=1, index=0.
- Latency: the wide word is visible on d_* one cycle after the last beat is accepted.
- Simultaneous events: if d_ack_i and the last beat arrive in the same cycle, the old word retires and the new word loads on that edge with no bubble. Sustained throughput is one beat per clock.
- Output hold: d_dat_o and d_tgc_o stay stable while d_stb_o=1 and d_ack_i=0.
- d_ack_i while out_valid=0 is ignored.
- s_cyc_i deassertion does not clear partial state.

Optional Feature:
Macro WISH_PACK_ALIGN_EN.
- Defined: an accepted beat with s_tgc_i[0]=1 at index!=0 discards the partial accumulator, writes this beat to lane 0, and sets index=1. An accepted beat with s_tgc_i[1]=1 at index<NUM_PACK-1 drops the partial group and sets index=0; nothing is emitted.
- Undefined: tags never affect index; grouping is purely by count.

Decomposition:
- Package wish_pkg holds:
  - constants TGC_FIRST=0, TGC_LAST=1, TGC_WIDTH=2;
  - function lane_base(k, NUM_PACK, LITTLE_ENDIAN, DATA_WIDTH) returning the bit offset. The unpacker shares this function.
- One sub-module, wish_out_reg: the valid/ack holding register for the destination side.

Test Plan:
1. Reset, then beats 0x11,0x22,0x33,0x44 with tgc 01,00,00,10 and d_ack_i=1, LITTLE_ENDIAN=1 -> d_dat_o=0x44332211, d_tgc_o=11, d_stb_o high for one cycle.
2. Same beats with LITTLE_ENDIAN=0 -> d_dat_o=0x11223344.
3. Hold d_ack_i=0; send 8 beats 0x01..0x08 -> s_stall_o=1 on beat 0x08 and beat 0x08 is not acked; d_dat_o stays 0x04030201. Raise d_ack_i -> beat 0x08 acked the same cycle; next word is 0x08070605.
4. Continuous streaming with d_ack_i=1 for 3 groups -> no stall, one word every 4 clocks, tags correct on each word.
5. Assert rst_ni=0 after 2 beats, release, send 4 beats 0xA0..0xA3 -> d_dat_o=0xA3A2A1A0; no stale lanes from before reset.
6. With WISH_PACK_ALIGN_EN: beats 0x01,0x02 then 0x10(tgc 01),0x20,0x30,0x40(tgc 10) -> a single word 0x40302010 with d_tgc_o=11. Without the macro -> first word 0x20100201.

Source files
------------

// File: rtl/wish_pkg.sv
// Shared definitions for the wish_pack packer and its unpacker counterpart:
// tag bit positions and the lane-offset helper both directions agree on.
package wish_pkg;

   localparam int TGC_FIRST = 0;
   localparam int TGC_LAST  = 1;
   localparam int TGC_WIDTH = 2;

   // Bit offset of beat k inside the wide word for the given lane order.
   function automatic int lane_base(input int k, input int num_pack,
                                    input int little_endian, input int data_width);
      return ((little_endian != 0) ? k : (num_pack - 1 - k)) * data_width;
   endfunction

endpackage

// File: rtl/wish_out_reg.sv
// Destination-side holding register: loads a completed word, holds it
// stable until the consumer acks, and drops valid when the word retires.
module wish_out_reg
   import wish_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int TAG_WIDTH = TGC_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 load_i,
   input  logic                 ack_i,
   input  logic [WIDTH-1:0]     dat_i,
   input  logic [TAG_WIDTH-1:0] tgc_i,
   output logic                 valid_o,
   output logic [WIDTH-1:0]     dat_o,
   output logic [TAG_WIDTH-1:0] tgc_o
);

   logic                 valid_q, valid_d;
   logic [WIDTH-1:0]     dat_q,   dat_d;
   logic [TAG_WIDTH-1:0] tgc_q,   tgc_d;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      valid_d = valid_q;
      dat_d   = dat_q;
      tgc_d   = tgc_q;
      if (load_i) begin
         valid_d = 1'b1;
         dat_d   = dat_i;
         tgc_d   = tgc_i;
      end else if (valid_q && ack_i) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         dat_q   <= '0;
         tgc_q   <= '0;
      end else begin
         valid_q <= valid_d;
         dat_q   <= dat_d;
         tgc_q   <= tgc_d;
      end
   end

   assign valid_o = valid_q;
   assign dat_o   = dat_q;
   assign tgc_o   = tgc_q;

endmodule

// File: rtl/wish_pack.sv
// Wishbone-style packer: gathers NUM_PACK narrow beats into one wide word.
// Optional tag-driven realignment is enabled by defining WISH_PACK_ALIGN_EN.
module wish_pack
   import wish_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_PACK      = 4,
   parameter int LITTLE_ENDIAN = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           s_stb_i,
   input  logic                           s_cyc_i,
   output logic                           s_ack_o,
   output logic                           s_stall_o,
   input  logic [DATA_WIDTH-1:0]          s_dat_i,
   input  logic [TGC_WIDTH-1:0]           s_tgc_i,
   output logic                           d_stb_o,
   output logic                           d_cyc_o,
   input  logic                           d_ack_i,
   output logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o,
   output logic [TGC_WIDTH-1:0]           d_tgc_o
);

   localparam int                IDX_W    = $clog2(NUM_PACK);
   localparam int                WORD_W   = DATA_WIDTH * NUM_PACK;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PACK - 1);

   logic [IDX_W-1:0]                       idx_q, idx_d;
   logic [NUM_PACK-2:0][DATA_WIDTH-1:0]    acc_q, acc_d;
   logic                                   first_q, first_d;
   logic                                   out_valid;
   logic                                   beat_fire;
   logic                                   load;
   logic                                   last_beat;
   logic [WORD_W-1:0]                      word;

   assign last_beat = (idx_q == LAST_IDX);
   assign s_stall_o = last_beat & out_valid & ~d_ack_i;
   assign s_ack_o   = s_stb_i & s_cyc_i & ~s_stall_o;
   assign beat_fire = s_ack_o;

   always_comb begin
      idx_d   = idx_q;
      acc_d   = acc_q;
      first_d = first_q;
      load    = 1'b0;
      if (beat_fire) begin
`ifdef WISH_PACK_ALIGN_EN
         if (s_tgc_i[TGC_FIRST] && (idx_q != '0)) begin
            acc_d[0] = s_dat_i;
            first_d  = 1'b1;
            idx_d    = IDX_W'(1);
         end else if (s_tgc_i[TGC_LAST] && !last_beat) begin
            idx_d = '0;
         end else
`endif
         if (last_beat) begin
            load  = 1'b1;
            idx_d = '0;
         end else begin
            acc_d[idx_q] = s_dat_i;
            if (idx_q == '0) first_d = s_tgc_i[TGC_FIRST];
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   // The closing beat goes straight from the port into its lane, so no extra cycle is spent.
   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_PACK - 1; k++) begin
         word[lane_base(k, NUM_PACK, LITTLE_ENDIAN, DATA_WIDTH) +: DATA_WIDTH] = acc_q[k];
      end
      word[lane_base(NUM_PACK - 1, NUM_PACK, LITTLE_ENDIAN, DATA_WIDTH) +: DATA_WIDTH] = s_dat_i;
   end

   // NOTE: the accumulator is cleared on reset so no lane from a discarded group can leak into a later word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q   <= '0;
         acc_q   <= '0;
         first_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         first_q <= first_d;
      end
   end

   wish_out_reg #(
      .WIDTH     (WORD_W),
      .TAG_WIDTH (TGC_WIDTH)
   ) u_out_reg (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load),
      .ack_i   (d_ack_i),
      .dat_i   (word),
      .tgc_i   ({s_tgc_i[TGC_LAST], first_q}),
      .valid_o (out_valid),
      .dat_o   (d_dat_o),
      .tgc_o   (d_tgc_o)
   );

   assign d_stb_o = out_valid;
   assign d_cyc_o = out_valid;

endmodule

// File: tb/tb_wish_pack.sv
// Directed bench for wish_pack: two instances share the stimulus, one per lane order.
// Expectations for the alignment scenario follow WISH_PACK_ALIGN_EN.
module tb_wish_pack;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        s_stb_i, s_cyc_i, d_ack_i;
   logic [7:0]  s_dat_i;
   logic [1:0]  s_tgc_i;

   logic        s_ack_o, s_stall_o, d_stb_o, d_cyc_o;
   logic [31:0] d_dat_o;
   logic [1:0]  d_tgc_o;

   logic        be_s_ack_o, be_s_stall_o, be_d_stb_o, be_d_cyc_o;
   logic [31:0] be_d_dat_o;
   logic [1:0]  be_d_tgc_o;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int stall_cycles = 0;

   typedef struct {
      logic [31:0] dat_le;
      logic [31:0] dat_be;
      logic [1:0]  tgc;
      int          cyc;
   } word_t;
   word_t words[$];

   always #5 clk_i = ~clk_i;

   wish_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .LITTLE_ENDIAN(1)) u_le (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(s_ack_o), .s_stall_o(s_stall_o),
      .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i),
      .d_stb_o(d_stb_o), .d_cyc_o(d_cyc_o), .d_ack_i(d_ack_i),
      .d_dat_o(d_dat_o), .d_tgc_o(d_tgc_o)
   );

   wish_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .LITTLE_ENDIAN(0)) u_be (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(be_s_ack_o), .s_stall_o(be_s_stall_o),
      .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i),
      .d_stb_o(be_d_stb_o), .d_cyc_o(be_d_cyc_o), .d_ack_i(d_ack_i),
      .d_dat_o(be_d_dat_o), .d_tgc_o(be_d_tgc_o)
   );

   always @(posedge clk_i) cycle <= cycle + 1;

   // Words retire on the next rising edge; inputs are stable from here to that edge.
   always @(negedge clk_i) begin
      if (rst_ni && d_stb_o && d_ack_i)
         words.push_back('{dat_le: d_dat_o, dat_be: be_d_dat_o, tgc: d_tgc_o, cyc: cycle});
      if (rst_ni && s_stall_o) stall_cycles++;
   end

   task automatic beat(input logic [7:0] d, input logic [1:0] t);
      int n;
      s_stb_i = 1'b1;
      s_cyc_i = 1'b1;
      s_dat_i = d;
      s_tgc_i = t;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!s_ack_o && n < 20);
      checks++;
      if (s_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL beat_ack dat=%h: s_ack_o=%b required 1 within 20 cycles", d, s_ack_o);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      s_stb_i = 1'b0;
      s_cyc_i = 1'b0;
      s_tgc_i = 2'b00;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset;
      rst_ni  = 1'b0;
      s_stb_i = 1'b0;
      s_cyc_i = 1'b0;
      s_dat_i = '0;
      s_tgc_i = '0;
      d_ack_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if ({d_stb_o, d_cyc_o, s_stall_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: stb/cyc/stall=%b required 000", {d_stb_o, d_cyc_o, s_stall_o});
      end
      checks++;
      if (d_dat_o !== 32'h0 || d_tgc_o !== 2'b00) begin
         errors++;
         $display("FAIL reset_data: dat=%h tgc=%b required 00000000/00", d_dat_o, d_tgc_o);
      end
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      idle(1);
   endtask

   task automatic test_basic_order;
      d_ack_i = 1'b1;
      beat(8'h11, 2'b01);
      beat(8'h22, 2'b00);
      beat(8'h33, 2'b00);
      beat(8'h44, 2'b10);
      s_stb_i = 1'b0;
      s_cyc_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (d_stb_o !== 1'b1 || d_cyc_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_valid: stb=%b cyc=%b required 1/1", d_stb_o, d_cyc_o);
      end
      checks++;
      if (d_dat_o !== 32'h44332211) begin
         errors++;
         $display("FAIL basic_le_dat: got %h required 44332211", d_dat_o);
      end
      checks++;
      if (be_d_dat_o !== 32'h11223344) begin
         errors++;
         $display("FAIL basic_be_dat: got %h required 11223344", be_d_dat_o);
      end
      checks++;
      if (d_tgc_o !== 2'b11) begin
         errors++;
         $display("FAIL basic_tgc: got %b required 11", d_tgc_o);
      end
      @(negedge clk_i);
      checks++;
      if (d_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_one_cycle: stb=%b required 0", d_stb_o);
      end
      idle(1);
   endtask

   task automatic test_stall;
      logic [1:0] t;
      d_ack_i = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         t = (i == 1 || i == 5) ? 2'b01 : ((i == 4) ? 2'b10 : 2'b00);
         beat(8'(i), t);
      end
      s_stb_i = 1'b1;
      s_cyc_i = 1'b1;
      s_dat_i = 8'h08;
      s_tgc_i = 2'b10;
      repeat (2) begin
         @(negedge clk_i);
         checks++;
         if (s_stall_o !== 1'b1 || s_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: stall=%b ack=%b required 1/0", s_stall_o, s_ack_o);
         end
         checks++;
         if (d_dat_o !== 32'h04030201 || d_tgc_o !== 2'b11 || d_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_out_hold: dat=%h tgc=%b stb=%b required 04030201/11/1",
                     d_dat_o, d_tgc_o, d_stb_o);
         end
      end
      d_ack_i = 1'b1;
      #1;
      checks++;
      if (s_ack_o !== 1'b1 || s_stall_o !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: ack=%b stall=%b required 1/0", s_ack_o, s_stall_o);
      end
      @(posedge clk_i);
      #1;
      s_stb_i = 1'b0;
      s_cyc_i = 1'b0;
      checks++;
      if (d_dat_o !== 32'h08070605 || d_tgc_o !== 2'b11 || d_stb_o !== 1'b1) begin
         errors++;
         $display("FAIL stall_next_word: dat=%h tgc=%b stb=%b required 08070605/11/1",
                  d_dat_o, d_tgc_o, d_stb_o);
      end
      idle(2);
   endtask

   task automatic test_back_to_back;
      logic [1:0]  first_t[3] = '{2'b01, 2'b00, 2'b01};
      logic [1:0]  last_t[3]  = '{2'b10, 2'b10, 2'b00};
      logic [1:0]  exp_tgc[3] = '{2'b11, 2'b10, 2'b01};
      logic [31:0] exp_le, exp_be;
      logic [7:0]  b;
      d_ack_i = 1'b1;
      words.delete();
      stall_cycles = 0;
      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(16 * (g + 1) + k);
            beat(b, (k == 0) ? first_t[g] : ((k == 3) ? last_t[g] : 2'b00));
         end
      end
      idle(3);
      checks++;
      if (words.size() != 3) begin
         errors++;
         $display("FAIL stream_count: got %0d words required 3", words.size());
      end
      checks++;
      if (stall_cycles != 0) begin
         errors++;
         $display("FAIL stream_no_stall: got %0d stall cycles required 0", stall_cycles);
      end
      for (int g = 0; g < 3 && g < words.size(); g++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(16 * (g + 1) + k);
            exp_le[k*8 +: 8]       = b;
            exp_be[(3 - k)*8 +: 8] = b;
         end
         checks++;
         if (words[g].dat_le !== exp_le || words[g].dat_be !== exp_be || words[g].tgc !== exp_tgc[g]) begin
            errors++;
            $display("FAIL stream_word%0d: le=%h be=%h tgc=%b required %h/%h/%b",
                     g, words[g].dat_le, words[g].dat_be, words[g].tgc, exp_le, exp_be, exp_tgc[g]);
         end
         if (g > 0) begin
            checks++;
            if (words[g].cyc - words[g-1].cyc != 4) begin
               errors++;
               $display("FAIL stream_spacing%0d: got %0d clocks required 4",
                        g, words[g].cyc - words[g-1].cyc);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      d_ack_i = 1'b1;
      beat(8'h55, 2'b01);
      beat(8'h66, 2'b00);
      rst_ni = 1'b0;
      #1;
      checks++;
      if (d_dat_o !== 32'h0 || d_tgc_o !== 2'b00 || d_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: dat=%h tgc=%b stb=%b required 00000000/00/0",
                  d_dat_o, d_tgc_o, d_stb_o);
      end
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      beat(8'hA0, 2'b01);
      beat(8'hA1, 2'b00);
      beat(8'hA2, 2'b00);
      beat(8'hA3, 2'b10);
      s_stb_i = 1'b0;
      s_cyc_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (d_dat_o !== 32'hA3A2A1A0 || be_d_dat_o !== 32'hA0A1A2A3 || d_stb_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_regroup: le=%h be=%h stb=%b required A3A2A1A0/A0A1A2A3/1",
                  d_dat_o, be_d_dat_o, d_stb_o);
      end
      idle(2);
   endtask

   task automatic test_align;
`ifdef WISH_PACK_ALIGN_EN
      logic [31:0] exp_dat = 32'h40302010;
      logic [1:0]  exp_tgc = 2'b11;
`else
      logic [31:0] exp_dat = 32'h20100201;
      logic [1:0]  exp_tgc = 2'b00;
`endif
      d_ack_i = 1'b1;
      words.delete();
      beat(8'h01, 2'b00);
      beat(8'h02, 2'b00);
      beat(8'h10, 2'b01);
      beat(8'h20, 2'b00);
      beat(8'h30, 2'b00);
      beat(8'h40, 2'b10);
      idle(3);
      checks++;
      if (words.size() != 1) begin
         errors++;
         $display("FAIL align_count: got %0d words required 1", words.size());
      end
      if (words.size() > 0) begin
         checks++;
         if (words[0].dat_le !== exp_dat || words[0].tgc !== exp_tgc) begin
            errors++;
            $display("FAIL align_word: dat=%h tgc=%b required %h/%b",
                     words[0].dat_le, words[0].tgc, exp_dat, exp_tgc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_order();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_align();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
